// File: rtl/slib_pkg.sv
// Shared helpers for the slib FIFO family: size/width arithmetic used to derive
// pointer, usage and depth widths from the log2 depth parameter.
package slib_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) res = res + 32'd1;
        return res;
    endfunction

    // Pointers and the usage count carry one extra bit so 0..DEPTH is exact.
    function automatic int unsigned ptr_width(input int unsigned size_e);
        return size_e + 32'd1;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned size_e);
        return 32'd1 << size_e;
    endfunction

endpackage

// File: rtl/slib_fifo_ptr.sv
// Wrap-bit FIFO pointer: increments when enabled, synchronous clear, async reset.
module slib_fifo_ptr #(
    parameter int unsigned PTR_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/slib_fifo_lvl.sv
// First-word-fall-through FIFO with exact usage count, trigger/almost-full levels
// and sticky overrun/underrun. Optional per-entry error tag: SLIB_FIFO_ERRTRACK_EN.
module slib_fifo_lvl
    import slib_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SIZE_E  = 6,
    parameter int unsigned AFULL_M = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLEAR,
    input  logic              WRITE,
    input  logic              READ,
    input  logic [WIDTH-1:0]  D,
    input  logic [SIZE_E:0]   TRIG,
    output logic [WIDTH-1:0]  Q,
    output logic              EMPTY,
    output logic              FULL,
    output logic              ALMOST_FULL,
    output logic              TRIG_HIT,
    output logic              OVERRUN,
    output logic              UNDERRUN,
    output logic [SIZE_E:0]   USAGE
`ifdef SLIB_FIFO_ERRTRACK_EN
    ,
    input  logic              D_ERR,
    output logic              Q_ERR,
    output logic              ERR_ANY
`endif
);

    localparam int unsigned PTR_W  = ptr_width(SIZE_E);
    localparam int unsigned DEPTH  = fifo_depth(SIZE_E);
    localparam int unsigned AF_LVL = (AFULL_M < DEPTH) ? DEPTH - AFULL_M : 0;
`ifdef SLIB_FIFO_ERRTRACK_EN
    localparam int unsigned MEM_W  = WIDTH + 1;
`else
    localparam int unsigned MEM_W  = WIDTH;
`endif

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] usage;
    logic [MEM_W-1:0] mem [DEPTH];
    logic [MEM_W-1:0] head;
    logic [MEM_W-1:0] wr_word;
    logic             empty_c;
    logic             full_c;
    logic             wr_acc;
    logic             rd_acc;
    logic             overrun_q;
    logic             underrun_q;

    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[SIZE_E-1:0] == rd_ptr[SIZE_E-1:0]) && (wr_ptr[SIZE_E] != rd_ptr[SIZE_E]);

    // A read frees the slot on a full FIFO; a read on an empty FIFO is ignored.
    assign wr_acc = !CLEAR && WRITE && (!full_c || READ);
    assign rd_acc = !CLEAR && READ && !empty_c;

    slib_fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (CLEAR),
        .en    (wr_acc),
        .ptr   (wr_ptr)
    );

    slib_fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (CLEAR),
        .en    (rd_acc),
        .ptr   (rd_ptr)
    );

    // Storage is intentionally not reset.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr[SIZE_E-1:0]] <= wr_word;
        end
    end

    assign head = mem[rd_ptr[SIZE_E-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            usage <= '0;
        end else if (CLEAR) begin
            usage <= '0;
        end else if (wr_acc && !rd_acc) begin
            usage <= usage + PTR_W'(1);
        end else if (!wr_acc && rd_acc) begin
            usage <= usage - PTR_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else if (CLEAR) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (WRITE && full_c && !READ) overrun_q  <= 1'b1;
            if (READ && empty_c)          underrun_q <= 1'b1;
        end
    end

    assign Q           = head[WIDTH-1:0];
    assign EMPTY       = empty_c;
    assign FULL        = full_c;
    assign USAGE       = usage;
    assign ALMOST_FULL = (usage >= PTR_W'(AF_LVL));
    assign TRIG_HIT    = (TRIG != '0) && (usage >= TRIG);
    assign OVERRUN     = overrun_q;
    assign UNDERRUN    = underrun_q;

`ifdef SLIB_FIFO_ERRTRACK_EN
    logic [PTR_W-1:0] err_cnt;
    logic             err_inc;
    logic             err_dec;

    assign wr_word = {D_ERR, D};
    assign err_inc = wr_acc && D_ERR;
    assign err_dec = rd_acc && head[WIDTH];

    // Count of tagged entries currently held.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_cnt <= '0;
        end else if (CLEAR) begin
            err_cnt <= '0;
        end else if (err_inc && !err_dec) begin
            err_cnt <= err_cnt + PTR_W'(1);
        end else if (!err_inc && err_dec) begin
            err_cnt <= err_cnt - PTR_W'(1);
        end
    end

    assign Q_ERR   = !empty_c && head[WIDTH];
    assign ERR_ANY = (err_cnt != '0);
`else
    assign wr_word = D;
`endif

endmodule
